// File: rtl/arb4_rr_pkg.sv
// Shared definitions for the four-way round-robin arbiter.
// FSM encoding is kept as plain constants so older code can match on it directly.
package arb4_rr_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    typedef logic [1:0] idx_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first asserted request starting at ptr, wrapping mod 4.
module rr_pick4
    import arb4_rr_pkg::*;
(
    input  logic [3:0] req,
    input  idx_t       ptr,
    output idx_t       win,
    output logic       any
);

    // Walk offsets from farthest to nearest so the nearest hit overwrites the others.
    always_comb begin
        idx_t cand;
        cand = ptr;
        win  = ptr;
        any  = |req;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr + 2'(i);
            if (req[cand]) begin
                win = cand;
            end
        end
    end

endmodule

// File: rtl/arb4_rr.sv
// Four-requester round-robin arbiter with hold timeout, one-hot and encoded grant outputs.
// Owners are always separated by at least one idle cycle.
module arb4_rr
    import arb4_rr_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 15,
    parameter int unsigned CNT_W    = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a0,
    input  logic a1,
    input  logic a2,
    input  logic a3,
    input  logic done,
    output logic g0,
    output logic g1,
    output logic g2,
    output logic g3,
    output logic y0,
    output logic y1,
    output logic gv,
    output logic tout
);

    if ((HOLD_MAX >> CNT_W) != 0) begin : g_bad_cnt_w
        $error("CNT_W too narrow for HOLD_MAX");
    end

    logic [0:0]       state_q, state_d;
    idx_t             ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       grant_q, grant_d;
    idx_t             idx_q, idx_d;
    logic             tout_q, tout_d;

    logic [3:0] req;
    idx_t       win;
    logic       any_req;
    logic       own_req;
    logic       hold_hit;
    logic       release_now;

    assign req = {a3, a2, a1, a0};

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr_q),
        .win (win),
        .any (any_req)
    );

    assign own_req     = req[idx_q];
    assign hold_hit    = (HOLD_MAX != 0) && (cnt_q == CNT_W'(HOLD_MAX - 1));
    assign release_now = done | ~own_req | hold_hit;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        tout_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_BUSY;
                    grant_d = 4'b0001 << win;
                    idx_d   = win;
                    ptr_d   = win + 2'd1;
                    cnt_d   = '0;
                end
            end
            ST_BUSY: begin
                if (release_now) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    idx_d   = '0;
                    // Only a pure timeout is flagged; done wins when both coincide.
                    tout_d  = hold_hit & ~done & own_req;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            idx_q   <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            tout_q  <= tout_d;
        end
    end

    assign g0   = grant_q[0];
    assign g1   = grant_q[1];
    assign g2   = grant_q[2];
    assign g3   = grant_q[3];
    assign y0   = idx_q[0];
    assign y1   = idx_q[1];
    assign gv   = |grant_q;
    assign tout = tout_q;

endmodule

// File: tb/tb_arb4_rr.sv
// Bench for arb4_rr: three instances (HOLD_MAX 15, 4, 2) on shared stimulus, each checked
// every cycle against a behavioural owner/pointer model, plus directed literal checks.
module tb_arb4_rr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] a;
    logic       done;

    // Per instance: [3:0]=g3..g0, [4]=y0, [5]=y1, [6]=gv, [7]=tout
    wire [7:0] o [3];

    int total = 0;
    int bad   = 0;

    int hold_tab [3] = '{15, 4, 2};
    int m_owner  [3] = '{-1, -1, -1};
    int m_ptr    [3] = '{0, 0, 0};
    int m_held   [3] = '{0, 0, 0};
    bit m_tout   [3] = '{1'b0, 1'b0, 1'b0};

    logic [7:0] seq_exp [4] = '{8'h41, 8'h52, 8'h64, 8'h78};

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        arb4_rr #(
            .HOLD_MAX (gi == 0 ? 15 : (gi == 1 ? 4 : 2)),
            .CNT_W    (8)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .a0    (a[0]),
            .a1    (a[1]),
            .a2    (a[2]),
            .a3    (a[3]),
            .done  (done),
            .g0    (o[gi][0]),
            .g1    (o[gi][1]),
            .g2    (o[gi][2]),
            .g3    (o[gi][3]),
            .y0    (o[gi][4]),
            .y1    (o[gi][5]),
            .gv    (o[gi][6]),
            .tout  (o[gi][7])
        );
    end

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%02h expected=%02h", nm, $time, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_vec(input int owner, input bit t);
        logic [7:0] e;
        e = 8'h00;
        if (owner >= 0) begin
            e[owner] = 1'b1;
            e[5:4]   = 2'(owner);
            e[6]     = 1'b1;
        end
        e[7] = t;
        return e;
    endfunction

    // Model: who owns the resource, for how many cycles, and where the search starts next.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_owner[i] = -1;
                m_ptr[i]   = 0;
                m_held[i]  = 0;
                m_tout[i]  = 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                m_tout[i] = 1'b0;
                if (m_owner[i] < 0) begin
                    for (int off = 0; off < 4; off++) begin
                        int k;
                        k = (m_ptr[i] + off) % 4;
                        if (a[k] && m_owner[i] < 0) begin
                            m_owner[i] = k;
                            m_ptr[i]   = (k + 1) % 4;
                            m_held[i]  = 1;
                        end
                    end
                end else begin
                    bit timed, still;
                    timed = (hold_tab[i] != 0) && (m_held[i] == hold_tab[i]);
                    still = a[m_owner[i]];
                    if (done || !still || timed) begin
                        m_tout[i]  = timed && !done && still;
                        m_owner[i] = -1;
                    end else begin
                        m_held[i]++;
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("model_cmp[%0d]", i), o[i], exp_vec(m_owner[i], m_tout[i]));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        a     = 4'h0;
        done  = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        chk("reset_out", o[0], 8'h00);

        // All requesting out of reset: 0 first, then 1 after done.
        a     = 4'hF;
        rst_n = 1'b1;
        step();
        chk("t1_grant0", o[0], 8'h41);
        done = 1'b1;
        step();
        chk("t1_release", o[0], 8'h00);
        done = 1'b0;
        step();
        chk("t1_grant1", o[0], 8'h52);

        // Owner withdraws; lone a2 then wins; dropping a2 releases without tout.
        a = 4'h4;
        step();
        chk("t2_withdraw", o[0], 8'h00);
        step();
        chk("t2_grant2", o[0], 8'h64);
        a = 4'h0;
        step();
        chk("t2_drop", o[0], 8'h00);

        // HOLD_MAX=4 instance: four grant cycles, tout pulse, regrant.
        a = 4'h8;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_hold", o[1], 8'h78);
        end
        step();
        chk("t3_tout", o[1], 8'h80);
        step();
        chk("t3_regrant", o[1], 8'h78);
        a = 4'h0;

        // Rotation with done held: 0,1,2,3,0 separated by idle cycles.
        a    = 4'hF;
        done = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_seq", o[0], seq_exp[i % 4]);
            step();
            chk("t4_gap", o[0], 8'h00);
        end
        done = 1'b0;

        // Asynchronous reset between edges drops the grant immediately.
        a = 4'h4;
        do_reset();
        step();
        chk("t5_busy", o[0], 8'h64);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async0", o[0], 8'h00);
        chk("t5_async1", o[1], 8'h00);
        a = 4'h3;
        step();
        rst_n = 1'b1;
        step();
        chk("t5_ptr0", o[0], 8'h41);

        // HOLD_MAX=2 instance: done coincides with timeout, so no tout.
        a = 4'h1;
        do_reset();
        step();
        chk("t6_busy1", o[2], 8'h41);
        step();
        chk("t6_busy2", o[2], 8'h41);
        done = 1'b1;
        step();
        chk("t6_done_tmo", o[2], 8'h00);
        done = 1'b0;
        a    = 4'h0;

        // Random traffic with slowly changing requests so timeouts occur.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            step();
            if ($urandom_range(0, 15) == 0) a = 4'($urandom);
            done  = ($urandom_range(0, 23) == 0);
            rst_n = ($urandom_range(0, 299) != 0);
        end
        rst_n = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arb4_rr.md
Name: arb4_rr

Overview:
- Four-requester round-robin arbiter that gives one shared resource to a single owner at a time.
- Grant is presented both one-hot and as a 2-bit encoded index. The encoding matches the team's 4-to-2 encoder convention.
- Sits in front of any shared datapath resource.
- Ownership is held until the owner signals done, withdraws its request, or a hold timeout expires.

Parameters:
- HOLD_MAX, 15: maximum BUSY cycles per grant before forced release. Legal range 0..255; 0 disables the timeout.
- CNT_W, 8: width of the hold counter. Must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a0  input  1  request from requester 0
- a1  input  1  request from requester 1
- a2  input  1  request from requester 2
- a3  input  1  request from requester 3
- done  input  1  current owner finished; sampled only in BUSY
- g0  output  1  grant to requester 0 (registered)
- g1  output  1  grant to requester 1 (registered)
- g2  output  1  grant to requester 2 (registered)
- g3  output  1  grant to requester 3 (registered)
- y0  output  1  encoded owner index, bit 0 (registered)
- y1  output  1  encoded owner index, bit 1 (registered)
- gv  output  1  grant valid: high exactly when one of g0..g3 is high
- tout  output  1  one-cycle pulse, forced release by timeout

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - rst_n is asynchronous, active-low. Assertion takes effect immediately, independent of clk.
  - Reset values: state=IDLE, ptr=0, cnt=0, g0..g3=0, y0=y1=0, gv=0, tout=0.
  - Reset mid-grant drops the grant at once. No done or tout is generated.
- State machine (two states, IDLE and BUSY):
  - IDLE, no request: stay in IDLE, outputs low.
  - IDLE, any request: pick a winner k by round-robin. Next cycle: g[k]=1, {y1,y0}=k, gv=1, ptr=(k+1) mod 4, cnt=0, state=BUSY.
- Round-robin winner:
  - Search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first asserted request wins.
  - After reset ptr=0, so a0 has highest priority first.
- BUSY, release conditions:
  - done=1, or owner's own request low, or (HOLD_MAX!=0 and cnt==HOLD_MAX-1).
  - Any of these: next cycle g*, gv, y* all 0 and state=IDLE.
  - Release by timeout only (no done, request still high): tout=1 for that one cycle.
- BUSY, no release: cnt increments; grants are held steady.
- Requests from non-owners during BUSY are ignored. They are arbitrated in IDLE.
- Timing:
  - Request in IDLE at edge N: grant visible after edge N+1. Latency is 1 cycle.
  - done sampled at edge M: grant low after M+1. Next grant earliest after M+2.
  - There is always at least one idle cycle between owners. Owners never overlap.
- Simultaneous release conditions: done together with timeout counts as a normal release, tout=0.
- Owner re-request: the owner may keep its request high after release. It loses priority, because ptr has already advanced past it.
- y0/y1 are only meaningful when gv=1 and are forced to 0 when gv=0.
- Invariant: at most one of g0..g3 is high in any cycle.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=1'b0, ST_BUSY=1'b1).
- One natural sub-module, rr_pick4: combinational.
  - Inputs: {a3,a2,a1,a0} and ptr.
  - Outputs: winner index (2 bits) and any-request flag.
- FSM, counter, pointer and output registers stay in arb4_rr.

Test Plan:
- Reset with a0..a3=1111, then release reset:
  - grant after 1 cycle to 0 (g0=1, y1y0=00, gv=1).
  - done pulse: grant drops, then next grant goes to 1 (y1y0=01).
- Only a2 high from IDLE: g2=1, y1y0=10 one cycle later.
  - Drop a2 with done=0: grant drops next cycle, tout=0.
- HOLD_MAX=4, a3 held high, done never asserted:
  - g3 high for exactly 4 cycles, then grant drops with tout=1 for one cycle.
  - Regrant to 3 follows after the idle cycle.
- All four requests held, done pulsed on every grant:
  - grant sequence 0,1,2,3,0.
  - gv shows one low cycle between each grant.
- Assert rst_n=0 asynchronously mid-BUSY, between clock edges:
  - all outputs 0 immediately.
  - after release, a1 and a0 high: a0 wins (ptr back at 0).
- done and timeout in the same cycle (HOLD_MAX=2, done asserted on the 2nd BUSY cycle):
  - release occurs with tout=0.
